// File: rtl/sha1_hash_engine.sv
// sha1_hash_engine: multi-block SHA-1 compression engine.
//
// Hashes one pre-padded 512-bit block per request and chains the
// intermediate hash H across blocks, so messages of any length can be
// processed. ROUNDS_PER_CYCLE rounds execute in each clock. The message
// schedule is produced from a sliding 16-word window that advances by
// ROUNDS_PER_CYCLE words per clock.
//
// Ports:
//   CLK       in   1    clock, rising edge
//   nRST      in   1    asynchronous active-low reset
//   START     in   1    block request, accepted only while READY=1
//   INIT      in   1    with START: 1 = first block (H from IV), 0 = chain
//   BLOCK_IN  in   512  padded block, W[0] = BLOCK_IN[511:480]
//   READY     out  1    engine idle, START will be accepted
//   DONE      out  1    one-cycle pulse, DIGEST updated
//   DIGEST    out  160  {H0,H1,H2,H3,H4}, held until the next DONE
module sha1_hash_engine #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         START,
  input  logic         INIT,
  input  logic [511:0] BLOCK_IN,
  output logic         READY,
  output logic         DONE,
  output logic [159:0] DIGEST
);

  localparam int unsigned R      = ROUNDS_PER_CYCLE;
  localparam logic [6:0]  LastT  = 7'(80 - R);
  localparam logic [6:0]  StepT  = 7'(R);

  localparam logic [0:4][31:0] Iv = {
    32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0
  };

  // Only divisors of 20 keep every cycle inside one f/K segment and make
  // the round counter land exactly on 80.
  generate
    if (!(R == 1 || R == 2 || R == 4 || R == 5)) begin : g_bad_rounds_per_cycle
      $error("sha1_hash_engine: ROUNDS_PER_CYCLE must be 1, 2, 4 or 5");
    end
  endgenerate

  typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

  state_e               state_q, state_d;
  logic [6:0]           t_q, t_d;
  logic [0:15][31:0]    w_q, w_d;       // w_q[i] holds W[t+i]
  logic [0:4][31:0]     abcde_q, abcde_d;
  logic [0:4][31:0]     h_q, h_d;
  logic [159:0]         digest_q, digest_d;
  logic                 done_q, done_d;

  logic [0:4][31:0]     abcde_rounds;
  logic [0:15][31:0]    w_next;
  logic [0:4][31:0]     h_sum;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] rotl5(input logic [31:0] x);
    return {x[26:0], x[31:27]};
  endfunction

  function automatic logic [31:0] rotl30(input logic [31:0] x);
    return {x[1:0], x[31:2]};
  endfunction

  function automatic logic [31:0] f_fn(input logic [6:0] rnd, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
    logic [31:0] f;
    if (rnd < 7'd20) begin
      f = (b & c) | (~b & d);
    end else if (rnd < 7'd40) begin
      f = b ^ c ^ d;
    end else if (rnd < 7'd60) begin
      f = (b & c) | (b & d) | (c & d);
    end else begin
      f = b ^ c ^ d;
    end
    return f;
  endfunction

  function automatic logic [31:0] k_fn(input logic [6:0] rnd);
    logic [31:0] k;
    if (rnd < 7'd20) begin
      k = 32'h5a827999;
    end else if (rnd < 7'd40) begin
      k = 32'h6ed9eba1;
    end else if (rnd < 7'd60) begin
      k = 32'h8f1bbcdc;
    end else begin
      k = 32'hca62c1d6;
    end
    return k;
  endfunction

  // R chained rounds t0 .. t0+R-1 using W[t0+j] = w[j].
  function automatic logic [0:4][31:0] run_rounds(input logic [0:4][31:0] s,
                                                  input logic [6:0] t0,
                                                  input logic [0:15][31:0] w);
    logic [31:0] a, b, c, d, e, tmp;
    logic [6:0]  rnd;
    a = s[0];
    b = s[1];
    c = s[2];
    d = s[3];
    e = s[4];
    for (int unsigned j = 0; j < R; j++) begin
      rnd = t0 + 7'(j);
      tmp = rotl5(a) + f_fn(rnd, b, c, d) + e + k_fn(rnd) + w[4'(j)];
      e   = d;
      d   = c;
      c   = rotl30(b);
      b   = a;
      a   = tmp;
    end
    return {a, b, c, d, e};
  endfunction

  // Extends the window by R new words (each may depend on one computed
  // earlier in the same cycle) and drops the R oldest.
  function automatic logic [0:15][31:0] next_window(input logic [0:15][31:0] w);
    logic [31:0]       ext [32];
    logic [0:15][31:0] nw;
    for (int unsigned i = 0; i < 16; i++) begin
      ext[5'(i)] = w[4'(i)];
    end
    for (int unsigned j = 0; j < R; j++) begin
      ext[5'(16 + j)] = rotl1(ext[5'(13 + j)] ^ ext[5'(8 + j)] ^
                              ext[5'(2 + j)] ^ ext[5'(j)]);
    end
    for (int unsigned i = 0; i < 16; i++) begin
      nw[4'(i)] = ext[5'(i + R)];
    end
    return nw;
  endfunction

  assign abcde_rounds = run_rounds(abcde_q, t_q, w_q);
  assign w_next       = next_window(w_q);

  always_comb begin
    for (int unsigned i = 0; i < 5; i++) begin
      h_sum[3'(i)] = h_q[3'(i)] + abcde_q[3'(i)];
    end
  end

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    w_d      = w_q;
    abcde_d  = abcde_q;
    h_d      = h_q;
    digest_d = digest_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          w_d     = BLOCK_IN;
          h_d     = INIT ? Iv : h_q;
          abcde_d = INIT ? Iv : h_q;
          t_d     = 7'd0;
          state_d = StRound;
        end
      end
      StRound: begin
        abcde_d = abcde_rounds;
        w_d     = w_next;
        t_d     = t_q + StepT;
        if (t_q == LastT) begin
          state_d = StFinal;
        end
      end
      StFinal: begin
        h_d      = h_sum;
        digest_d = h_sum;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      t_q      <= 7'd0;
      w_q      <= '0;
      abcde_q  <= '0;
      h_q      <= Iv;
      digest_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      w_q      <= w_d;
      abcde_q  <= abcde_d;
      h_q      <= h_d;
      digest_q <= digest_d;
      done_q   <= done_d;
    end
  end

  assign READY  = (state_q == StIdle);
  assign DONE   = done_q;
  assign DIGEST = digest_q;

endmodule

// File: tb/tb_sha1_hash_engine.sv
// Self-checking bench for sha1_hash_engine: a ROUNDS_PER_CYCLE=1 instance
// with a digest scoreboard, plus R=2/4/5 instances sharing one stimulus.
module tb_sha1_hash_engine;

  logic         CLK;
  logic         nRST;
  logic         start, init;
  logic [511:0] block;
  logic         ready, done;
  logic [159:0] digest;

  logic         start_s, init_s;
  logic [511:0] block_s;
  logic [2:0]   ready_s, done_s;
  logic [159:0] digest_s [3];

  typedef struct packed {
    logic         chk;
    logic [159:0] dig;
  } sb_t;

  sb_t sb[$];
  sb_t ent;
  int  checks, errors;
  int  cyc, acc_cyc, done_cyc, done_cnt, cnt0;
  int  lat_s [3];
  int  exp_lat_s [3];
  logic [159:0] dig_s [3];

  localparam logic [159:0] DigAbc   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DigEmpty = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] DigTwo   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  localparam logic [511:0] BlkAbc   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BlkEmpty = {32'h80000000, 480'h0};
  localparam logic [511:0] BlkTwo1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BlkTwo2  = {480'h0, 32'h000001c0};

  sha1_hash_engine #(.ROUNDS_PER_CYCLE(1)) u_dut (
    .CLK(CLK), .nRST(nRST), .START(start), .INIT(init), .BLOCK_IN(block),
    .READY(ready), .DONE(done), .DIGEST(digest)
  );

  sha1_hash_engine #(.ROUNDS_PER_CYCLE(2)) u_r2 (
    .CLK(CLK), .nRST(nRST), .START(start_s), .INIT(init_s), .BLOCK_IN(block_s),
    .READY(ready_s[0]), .DONE(done_s[0]), .DIGEST(digest_s[0])
  );

  sha1_hash_engine #(.ROUNDS_PER_CYCLE(4)) u_r4 (
    .CLK(CLK), .nRST(nRST), .START(start_s), .INIT(init_s), .BLOCK_IN(block_s),
    .READY(ready_s[1]), .DONE(done_s[1]), .DIGEST(digest_s[1])
  );

  sha1_hash_engine #(.ROUNDS_PER_CYCLE(5)) u_r5 (
    .CLK(CLK), .nRST(nRST), .START(start_s), .INIT(init_s), .BLOCK_IN(block_s),
    .READY(ready_s[2]), .DONE(done_s[2]), .DIGEST(digest_s[2])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial done_cnt = 0;
  always @(negedge CLK) if (done === 1'b1) done_cnt = done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the next posedge is the accepting edge.
  task automatic send(input logic [511:0] blk, input logic ini, input logic chk_dig,
                      input logic [159:0] exp);
    chk("ready_before_start", 160'(ready), 160'(1));
    start = 1'b1;
    init  = ini;
    block = blk;
    sb.push_back('{chk: chk_dig, dig: exp});
    @(posedge CLK);
    #1 acc_cyc = cyc;
    @(negedge CLK);
    start = 1'b0;
    init  = 1'($urandom_range(0, 1));
    block = {16{$urandom}};
  endtask

  task automatic wait_done(input int lat);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("done_seen", 160'(done), 160'(1));
    if (done === 1'b1 && sb.size() > 0) begin
      ent = sb.pop_front();
      if (ent.chk) chk("digest", digest, ent.dig);
      chk("latency", 160'(cyc - acc_cyc), 160'(lat));
      done_cyc = cyc;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST = 1'b0;
    start = 1'b0; init = 1'b0; block = '0;
    start_s = 1'b0; init_s = 1'b0; block_s = '0;
    exp_lat_s[0] = 41; exp_lat_s[1] = 21; exp_lat_s[2] = 17;

    // Reset values
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("rst_ready", 160'(ready), 160'(1));
    chk("rst_done", 160'(done), 160'(0));
    chk("rst_digest", digest, 160'h0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_sweep_ready", 160'(ready_s[i]), 160'(1));
      chk("rst_sweep_digest", digest_s[i], 160'h0);
    end

    // "abc" and empty message, R=1
    send(BlkAbc, 1'b1, 1'b1, DigAbc);
    wait_done(81);
    chk("done_cycle_ready", 160'(ready), 160'(1));
    @(negedge CLK);
    chk("done_is_pulse", 160'(done), 160'(0));
    send(BlkEmpty, 1'b1, 1'b1, DigEmpty);
    wait_done(81);
    @(negedge CLK);

    // Empty message, R=2/4/5
    start_s = 1'b1; init_s = 1'b1; block_s = BlkEmpty;
    @(posedge CLK);
    #1 acc_cyc = cyc;
    @(negedge CLK);
    start_s = 1'b0; block_s = {16{$urandom}};
    for (int i = 0; i < 3; i++) lat_s[i] = -1;
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (done_s[i] === 1'b1 && lat_s[i] < 0) begin
          lat_s[i] = cyc - acc_cyc;
          dig_s[i] = digest_s[i];
        end
      end
      @(negedge CLK);
    end
    for (int i = 0; i < 3; i++) begin
      chk("sweep_latency", 160'(lat_s[i]), 160'(exp_lat_s[i]));
      chk("sweep_digest", dig_s[i], DigEmpty);
    end

    // Two-block message, second block issued in the DONE cycle
    send(BlkTwo1, 1'b1, 1'b0, '0);
    wait_done(81);
    send(BlkTwo2, 1'b0, 1'b1, DigTwo);
    chk("no_gap", 160'(acc_cyc - done_cyc), 160'(1));
    wait_done(81);
    @(negedge CLK);

    // START and BLOCK_IN noise while busy
    cnt0 = done_cnt;
    send(BlkAbc, 1'b1, 1'b1, DigAbc);
    for (int i = 0; i < 40; i++) begin
      start = 1'($urandom_range(0, 1));
      init  = 1'($urandom_range(0, 1));
      block = {16{$urandom}};
      @(negedge CLK);
    end
    chk("busy_ready", 160'(ready), 160'(0));
    start = 1'b0;
    wait_done(81);
    repeat (90) @(negedge CLK);
    chk("one_done", 160'(done_cnt - cnt0), 160'(1));

    // Reset mid-round, then chained "abc" from IV
    cnt0 = done_cnt;
    send(BlkEmpty, 1'b1, 1'b1, DigEmpty);
    repeat (39) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("abort_ready", 160'(ready), 160'(1));
    chk("abort_done", 160'(done), 160'(0));
    chk("abort_digest", digest, 160'h0);
    sb.delete();
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    repeat (100) @(negedge CLK);
    chk("abort_no_done", 160'(done_cnt - cnt0), 160'(0));
    send(BlkAbc, 1'b0, 1'b1, DigAbc);
    wait_done(81);
    @(negedge CLK);

    // Fresh message after a digest reloads IV
    send(BlkAbc, 1'b1, 1'b1, DigAbc);
    wait_done(81);
    chk("sb_empty", 160'(sb.size()), 160'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha1_hash_engine.md
# sha1_hash_engine

Multi-block SHA-1 compression engine and the parametrised successor of the team's single-block SHA-1 core. It adds chaining-value carry-over across 512-bit blocks for arbitrary-length messages, a configurable number of rounds per clock, and an on-the-fly 16-word message schedule. It sits behind the message padder, which presents pre-padded 512-bit blocks, and returns a 160-bit digest with a one-cycle completion pulse.

## Interface
- ROUNDS_PER_CYCLE, 1, SHA-1 rounds per clock; legal values 1, 2, 4, 5; any other value is an elaboration error.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low; clock CLK.
- START  in  1  block request; accepted only when READY=1.
- INIT  in  1  sampled with START: 1 = first block of a message (H loaded from IV); 0 = continuation (chain from current H).
- BLOCK_IN  in  512  padded block, big-endian; W[0] = BLOCK_IN[511:480], W[15] = BLOCK_IN[31:0].
- READY  out  1  engine idle; START will be accepted.
- DONE  out  1  one-cycle pulse: DIGEST valid and updated.
- DIGEST  out  160  {H0,H1,H2,H3,H4}; held until the next DONE.

## Operation
- IV: H0..H4 = 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0. K = 5A827999 (t 0-19), 6ED9EBA1 (20-39), 8F1BBCDC (40-59), CA62C1D6 (60-79).
- f: Ch (B&C)|(~B&D) for t 0-19; Parity B^C^D for 20-39 and 60-79; Maj (B&C)|(B&D)|(C&D) for 40-59.
- FSM states:
  - IDLE: READY=1. START=1 moves to ROUND. On that same edge:
    - BLOCK_IN latched into the 16-word schedule register.
    - If INIT=1, H loads IV. A..E load the new H value (IV if INIT=1, else current H).
    - Round counter t=0.
  - ROUND: READY=0. Each edge executes ROUNDS_PER_CYCLE chained rounds t..t+R-1, then t advances by R. Leave to FINAL on the edge that executes round 79.
  - FINAL: Hi = Hi + {A..E}i mod 2^32. DIGEST is registered with the new H. DONE=1 for one cycle. Return to IDLE.
- Message schedule:
  - For t ≥ 16, W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]).
  - Computed from a 16-word shift window that shifts R words per cycle. No 80-word array.
  - Each f selection and K constant is chosen per round index within the cycle. This is exact because R divides 20.
- All arithmetic is 32-bit modulo 2^32. Rotations are true circular shifts (rotl5, rotl30).
- BLOCK_IN and INIT are don't-care except on the accepting edge. The source may change them while busy.
- START while READY=0 is ignored; the request is not queued.

## Timing
- Reset values: READY=1, DONE=0, DIGEST=0, H=IV, state IDLE, t=0.
- Accept edge k (START=1, READY=1).
  - Rounds occupy edges k+1 .. k+80/R.
  - FINAL at edge k+80/R+1: DONE=1 and DIGEST valid from that edge for one cycle; READY=1 in the same cycle.
- START→DONE latency = 80/R+1 cycles: 81, 41, 21, 17 for R = 1, 2, 4, 5.
- Back-to-back: START may be asserted in the DONE cycle. The next block's A..E load the just-updated H; there is no bubble cycle.
- Throughput: one block per 80/R+1 cycles.
- nRST low at any point:
  - Processing aborts immediately and outputs return to reset values.
  - The partial digest is discarded. DONE never pulses for the aborted block.
- A chained block (INIT=0) after reset with no prior INIT=1 hashes from IV. This is identical to INIT=1.

## Test plan
- "abc" single block (W0=61626380, W1..W14=0, W15=00000018), INIT=1, R=1 -> DONE at 81 cycles; DIGEST = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
- Empty message (W0=80000000, rest 0), INIT=1, swept over R=1,2,4,5 -> DIGEST = da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709; latency 81/41/21/17 cycles exactly.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" sent as block 1 INIT=1, block 2 INIT=0 in the DONE cycle -> second DIGEST = 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1; no idle gap between blocks.
- START pulses and BLOCK_IN changes during ROUND -> ignored; digest still matches the "abc" value; exactly one DONE.
- nRST low mid-ROUND (t≈40), then "abc" with INIT=0 -> no DONE for the aborted block; outputs at reset values; final DIGEST equals the "abc" value.
- After a digest, new "abc" with INIT=1 -> DIGEST returns to a9993e36…, confirming IV reload.
